pipe_stage_reg: RTL and testbench

Parametrised pipeline-boundary register carrying a generic payload plus write-enable-style control bits between two adjacent core stages (e.g. MEM→WB, EX→MEM). It adds what a plain register stage lacks: a valid/ready handshake for back-pressure, a synchronous flush that squashes the held instruction, and zero-gated control bits on bubbles. It also has a saturating stall counter and an optional skid entry that breaks the combinational ready path. One instance per stage boundary replaces the hand-written per-stage register blocks.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_slot.sv | 61 ++++++
 rtl/pipe_stage_reg.sv | 187 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the pipeline-boundary register:
//            default widths, the skid-entry occupancy state type and its
//            2-bit encoding constants.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

  localparam int unsigned c_DATA_W_DEF = 32;
  localparam int unsigned c_CTRL_W_DEF = 3;
  localparam int unsigned c_CNT_W_DEF  = 8;

  localparam logic [1:0] c_ST_EMPTY_ENC = 2'b00;
  localparam logic [1:0] c_ST_ONE_ENC   = 2'b01;
  localparam logic [1:0] c_ST_FULL_ENC  = 2'b10;

  // Occupancy of the stage when the skid entry is built in.
  typedef enum logic [1:0] {
    ST_EMPTY = c_ST_EMPTY_ENC,
    ST_ONE   = c_ST_ONE_ENC,
    ST_FULL  = c_ST_FULL_ENC
  } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Purpose  : One storage entry (valid + control + payload) of a pipeline
//            boundary register. Clear dominates load. Valid and control are
//            reset; the payload is intentionally left unreset.
// Ports    : clk, rst_n        clock, async active-low reset
//            i_load            capture i_ctrl/i_data and mark valid
//            i_clear           invalidate entry and zero its control bits
//            i_ctrl, i_data    values captured on load
//            o_valid, o_ctrl,  stored entry (o_ctrl is raw, not gated)
//            o_data
// Revision : 1.0  initial release
// ============================================================================
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int CTRL_W = c_CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
    end
  end

  // Payload has no reset so it maps onto plain enable flops.
  always_ff @(posedge clk) begin
    if (i_load && !i_clear) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Pipeline-boundary register with valid/ready back-pressure,
//            synchronous flush, zero-gated control bits on bubbles and a
//            saturating stall counter.
//            Build option: define PIPE_SKID_EN to add a second (skid) entry,
//            which makes in_ready a register output independent of
//            out_ready. Without it the stage is a single entry with a
//            combinational in_ready.
// Ports    : clk, rst_n                   clock, async active-low reset
//            in_valid/in_ready            upstream handshake
//            in_ctrl, in_data             upstream control bits and payload
//            flush                        squash held and incoming entries
//            out_valid/out_ready          downstream handshake
//            out_ctrl, out_data           held control (0 when invalid),
//                                         held payload
//            stall_cnt                    saturating stall-cycle count
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int CTRL_W = c_CTRL_W_DEF,
  parameter int CNT_W  = c_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic              w_main_load;
  logic              w_main_clear;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;
  logic              w_accept;
  logic              w_consume;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Flush drops anything offered in the same cycle even if in_ready is high.
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_consume = w_main_valid && out_ready;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_ctrl_in),
    .i_data  (w_main_data_in),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

`ifdef PIPE_SKID_EN
  state_t            r_state;
  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_skid_load;
  logic              w_skid_clear;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  // Skid valid is a flop, so in_ready has no path from out_ready.
  assign in_ready = !w_skid_valid;

  // Slot enables decoded from occupancy and this cycle's handshakes.
  always_comb begin
    w_main_load    = 1'b0;
    w_main_clear   = 1'b0;
    w_skid_load    = 1'b0;
    w_skid_clear   = 1'b0;
    w_main_ctrl_in = in_ctrl;
    w_main_data_in = in_data;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          w_main_load = w_accept;
        end
        ST_ONE: begin
          if (w_accept && !w_consume) begin
            w_skid_load = 1'b1;
          end else if (w_accept) begin
            w_main_load = 1'b1;
          end else if (w_consume) begin
            w_main_clear = 1'b1;
          end
        end
        ST_FULL: begin
          // Skid entry advances into the main slot when main drains.
          if (w_consume) begin
            w_main_load    = 1'b1;
            w_main_ctrl_in = w_skid_ctrl;
            w_main_data_in = w_skid_data;
            w_skid_clear   = 1'b1;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_consume) begin
            r_state <= ST_FULL;
          end else if (w_consume && !w_accept) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL:  if (w_consume) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end
`else
  // Single entry: room exists if empty or the held entry leaves this cycle.
  assign in_ready       = !w_main_valid || out_ready;
  assign w_main_load    = w_accept;
  assign w_main_clear   = flush || (w_consume && !w_accept);
  assign w_main_ctrl_in = in_ctrl;
  assign w_main_data_in = in_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
  assign out_data  = w_main_data;
  assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. A queue-based model of
//            the stage (capacity 1, or 2 with PIPE_SKID_EN) predicts every
//            output. A second instance with CNT_W=2 exercises saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int c_DW = 32;
  localparam int c_CW = 3;
`ifdef PIPE_SKID_EN
  localparam bit c_SKID = 1'b1;
`else
  localparam bit c_SKID = 1'b0;
`endif

  typedef struct packed {
    logic [c_CW-1:0] c;
    logic [c_DW-1:0] d;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [c_CW-1:0] in_ctrl;
  logic [c_DW-1:0] in_data;
  logic            flush;
  logic            out_ready;
  logic            in_ready, out_valid;
  logic [c_CW-1:0] out_ctrl;
  logic [c_DW-1:0] out_data;
  logic [7:0]      stall_cnt;
  logic            in_ready2, out_valid2;
  logic [c_CW-1:0] out_ctrl2;
  logic [c_DW-1:0] out_data2;
  logic [1:0]      stall_cnt2;

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  int   mcnt  = 0;
  int   mcnt2 = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(c_DW), .CTRL_W(c_CW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(c_DW), .CTRL_W(c_CW), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2),
    .out_data(out_data2), .stall_cnt(stall_cnt2)
  );

  function automatic bit m_ready();
    if (c_SKID) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic model_update();
    bit cons, acc;
    if (!rst_n) return;
    if (flush) begin
      mq.delete();
      mcnt  = 0;
      mcnt2 = 0;
    end else begin
      cons = (mq.size() > 0) && out_ready;
      acc  = in_valid && m_ready();
      if ((mq.size() > 0) && !out_ready) begin
        if (mcnt < 255) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back('{c: in_ctrl, d: in_data});
    end
  endtask

  // One rising edge with model update; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [c_CW-1:0] c,
                        input logic [c_DW-1:0] d, input logic f, input logic r);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 3'b110, 32'h55, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid actual=%b expected=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    mq.delete(); mcnt = 0; mcnt2 = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b expected=0", out_valid); end
    checks++;
    if (out_ctrl !== 3'b000) begin errors++; $display("FAIL reset_ctrl actual=%b expected=000", out_ctrl); end
    checks++;
    if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall actual=%0d expected=0", stall_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready actual=%b expected=1", in_ready); end
    @(negedge clk);
    set_in(1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_post_valid actual=%b expected=0", out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 3'(i), 32'h1000 + i, 1'b0, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready i=%0d actual=%b expected=1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1000 + i) begin
        errors++;
        $display("FAIL stream_data i=%0d actual=%b/%h expected=1/%h", i, out_valid, out_data, 32'h1000 + i);
      end
    end
    set_in(1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid actual=%b expected=0", out_valid); end
  endtask

  task automatic test_stall();
    logic exp_rdy;
    set_in(1'b1, 3'b011, 32'hDEAD, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 3'b000, 32'hB000 + k, 1'b0, 1'b0);
      exp_rdy = (c_SKID && k == 0) ? 1'b1 : 1'b0;
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL stall_in_ready k=%0d actual=%b expected=%b", k, in_ready, exp_rdy); end
      checks++;
      if (out_data !== 32'hDEAD) begin errors++; $display("FAIL stall_hold k=%0d actual=%h expected=0000dead", k, out_data); end
      tick();
    end
    checks++;
    if (stall_cnt !== 8'd5) begin errors++; $display("FAIL stall_cnt actual=%0d expected=5", stall_cnt); end
    checks++;
    if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL stall_sat actual=%0d expected=3", stall_cnt2); end
    set_in(1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_valid !== (mq.size() > 0) || (mq.size() > 0 && out_data !== mq[0].d)) begin
      errors++;
      $display("FAIL stall_drain actual=%b/%h expected=%b", out_valid, out_data, mq.size() > 0);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty actual=%b expected=0", out_valid); end
    checks++;
    if (stall_cnt !== 8'd5) begin errors++; $display("FAIL stall_keep actual=%0d expected=5", stall_cnt); end
  endtask

  task automatic test_flush();
    set_in(1'b1, 3'b101, 32'h1234, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_ctrl !== 3'b101) begin errors++; $display("FAIL flush_pre_ctrl actual=%b expected=101", out_ctrl); end
    set_in(1'b1, 3'b111, 32'hBEEF, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid actual=%b expected=0", out_valid); end
    checks++;
    if (out_ctrl !== 3'b000) begin errors++; $display("FAIL flush_ctrl actual=%b expected=000", out_ctrl); end
    checks++;
    if (stall_cnt !== 8'd0 || stall_cnt2 !== 2'd0) begin
      errors++; $display("FAIL flush_stall actual=%0d/%0d expected=0/0", stall_cnt, stall_cnt2);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data === 32'hBEEF) begin
      errors++; $display("FAIL flush_drop actual=%b/%h expected=0/not-beef", out_valid, out_data);
    end
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 3'b111, $urandom, 1'b0, 1'($urandom_range(0, 1)));
      tick();
      checks++;
      if (out_ctrl !== 3'b000 || out_valid !== 1'b0) begin
        errors++; $display("FAIL bubble_ctrl i=%0d actual=%b/%b expected=0/000", i, out_valid, out_ctrl);
      end
    end
  endtask

`ifdef PIPE_SKID_EN
  task automatic test_skid_drain();
    set_in(1'b1, 3'b001, 32'hAAAA0001, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 3'b010, 32'hBBBB0002, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_accept_b actual=%b expected=1", in_ready); end
    tick();
    set_in(1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'hAAAA0001) begin
      errors++; $display("FAIL skid_full actual=%b/%h expected=0/aaaa0001", in_ready, out_data);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hBBBB0002) begin
      errors++; $display("FAIL skid_second actual=%b/%b/%h expected=1/1/bbbb0002", in_ready, out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty actual=%b expected=0", out_valid); end
  endtask
`endif

  task automatic test_random();
    logic [c_CW-1:0] ec;
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 9) < 7), 3'($urandom), $urandom,
             1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) < 6));
      ec = (mq.size() > 0) ? mq[0].c : '0;
      checks++;
      if (in_ready !== m_ready() || in_ready2 !== m_ready()) begin
        errors++; $display("FAIL rand_in_ready n=%0d actual=%b/%b expected=%b", n, in_ready, in_ready2, m_ready());
      end
      checks++;
      if (out_valid !== (mq.size() > 0) || out_valid2 !== (mq.size() > 0)) begin
        errors++; $display("FAIL rand_valid n=%0d actual=%b/%b expected=%b", n, out_valid, out_valid2, mq.size() > 0);
      end
      checks++;
      if (out_ctrl !== ec || out_ctrl2 !== ec) begin
        errors++; $display("FAIL rand_ctrl n=%0d actual=%b/%b expected=%b", n, out_ctrl, out_ctrl2, ec);
      end
      if (mq.size() > 0) begin
        checks++;
        if (out_data !== mq[0].d || out_data2 !== mq[0].d) begin
          errors++; $display("FAIL rand_data n=%0d actual=%h/%h expected=%h", n, out_data, out_data2, mq[0].d);
        end
      end
      checks++;
      if (stall_cnt !== 8'(mcnt) || stall_cnt2 !== 2'(mcnt2)) begin
        errors++; $display("FAIL rand_stall n=%0d actual=%0d/%0d expected=%0d/%0d", n, stall_cnt, stall_cnt2, mcnt, mcnt2);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
`ifdef PIPE_SKID_EN
    test_skid_drain();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire
